mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store engine downstream of the multicycle control FSM.
- The FSM's memory states (load access, store complete) pulse a request into this block; it drives a req/gnt/rvalid data bus with variable latency.
- Handles byte/half/word lane steering, byte enables and load extension, plus alignment and timeout faults.
- Returns one formatted response per request to the datapath's data register.

Parameters:
- XLEN, 32, data and address width (only 32 supported).
- TIMEOUT, 16, max cycles from entering REQ to completion; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  single-cycle request pulse; accepted only when busy=0.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, value in the low bits.
- req_funct3  in  3  RISC-V funct3 size/sign field.
- busy  out  1  high in every state except IDLE.
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal or timed-out access.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- bus_req  out  1  bus request, held until grant.
- bus_we  out  1  bus write.
- bus_addr  out  XLEN  word address, req_addr with bits [1:0] forced to 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_gnt  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read word.

Behaviour:
- States: IDLE, REQ, WAIT, RESP, ERR.
- Reset (asynchronous, rst_n=0):
  - state returns to IDLE and the timeout counter clears;
  - all outputs go to 0 immediately, including mid-transaction (bus_req drops at once);
  - the aborted access produces no response.
- IDLE, on req_valid:
  - latch we, addr, wdata and funct3;
  - check the access:
    - funct3[1:0]=11 is illegal;
    - a half access with addr[0]=1 is misaligned;
    - a word access with addr[1:0]!=0 is misaligned;
    - a store with funct3[2]=1 is illegal;
  - on any fault go to ERR, otherwise go to REQ.
- req_valid while busy=1: ignored, with no queue and no state change.
- ERR: lasts one cycle with rsp_valid=1, rsp_err=1; no bus activity; then IDLE.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are registered and held stable until grant.
  - On bus_gnt with a store: go to RESP.
  - On bus_gnt with a load and bus_rvalid in the same cycle: capture bus_rdata, go to RESP (zero-wait read).
  - On bus_gnt with a load and no bus_rvalid: go to WAIT.
  - bus_req deasserts in the cycle after the grant.
- WAIT: on bus_rvalid, capture bus_rdata and go to RESP. bus_rvalid is ignored in IDLE and RESP.
- Timeout:
  - the counter clears on entering REQ and increments each cycle spent in REQ or WAIT;
  - when it equals TIMEOUT-1 with no completion, go to RESP with the error flag set;
  - if completion and timeout occur in the same cycle, completion wins.
- RESP: lasts one cycle with rsp_valid=1 and rsp_err equal to the timeout flag; then IDLE.
- Store byte-lane steering:
  - SB: bus_be = 4'b0001 << addr[1:0]; wdata byte replicated to all 4 lanes.
  - SH: bus_be = 4'b0011 << (2*addr[1]); halfword replicated to both halves.
  - SW: bus_be = 4'b1111; wdata passed through.
- Loads: bus_be = 4'b1111. Select the lane by addr[1:0]:
  - LB/LH sign-extend the selected byte/halfword;
  - LBU/LHU zero-extend it;
  - LW passes the word through.
- rsp_rdata is registered, valid only with rsp_valid, and 0 otherwise.
- Latency from req_valid (cycle 0):
  - store or zero-wait load with immediate grant: rsp_valid in cycle 2;
  - each cycle without grant, and each WAIT cycle, adds 1;
  - fault: rsp_valid in cycle 1.
- Throughput: a new req_valid is accepted in the cycle after rsp_valid.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt tied high -> cycle 1: bus_req=1, bus_addr=0x100, bus_be=1111, bus_wdata=0xDEADBEEF; cycle 2: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- LB addr=0x103, bus_rdata=0x80FF7F01, rvalid 3 cycles after grant -> rsp_rdata=0xFFFFFF80, with rsp_valid 3 cycles later than the zero-wait case. The same access as LBU -> 0x00000080.
- SH addr=0x206, wdata=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD. SH addr=0x205 -> cycle 1: rsp_valid=1, rsp_err=1, bus_req never asserted.
- LW with gnt withheld and TIMEOUT=16 -> bus_req held 16 cycles with stable address; then rsp_valid=1, rsp_err=1; busy falls the next cycle.
- Reset mid-access: pull rst_n low during WAIT -> bus_req, busy and rsp_valid are 0 in the same cycle; after release, no stale rsp_valid; the next LW completes normally.
- req_valid pulsed while busy -> ignored: exactly one rsp_valid, carrying the first request's data.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store engine: lane steering, load extension, alignment and timeout
// faults on a req/gnt/rvalid data bus. One response per accepted request.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            busy,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int CW = 16;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [1:0]      addr_q;
  logic [2:0]      f3_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [3:0]      bus_be_q;
  logic [XLEN-1:0] bus_wdata_q;

  logic            fault_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [7:0]      lb_d;
  logic [15:0]     lh_d;
  logic [XLEN-1:0] ext_d;
  logic            tmo_d;

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    fault_d = 1'b0;
    unique case (1'b1)
      (req_funct3[1:0] == 2'b11): fault_d = 1'b1;
      (req_funct3[1:0] == 2'b01): fault_d = req_addr[0];
      (req_funct3[1:0] == 2'b10): fault_d = |req_addr[1:0];
      default:                    fault_d = 1'b0;
    endcase
    if (req_we && req_funct3[2]) fault_d = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (req_we) begin
      unique case (req_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {req_addr[1], 1'b0};
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: wdata_d = req_wdata;
      endcase
    end
  end

  always_comb begin
    lb_d = bus_rdata[7:0];
    unique case (addr_q)
      2'd1:    lb_d = bus_rdata[15:8];
      2'd2:    lb_d = bus_rdata[23:16];
      2'd3:    lb_d = bus_rdata[31:24];
      default: lb_d = bus_rdata[7:0];
    endcase
    lh_d  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext_d = bus_rdata;
    unique case (f3_q)
      3'b000:  ext_d = {{24{lb_d[7]}}, lb_d};
      3'b001:  ext_d = {{16{lh_d[15]}}, lh_d};
      3'b100:  ext_d = {24'b0, lb_d};
      3'b101:  ext_d = {16'b0, lh_d};
      default: ext_d = bus_rdata;
    endcase
  end

  assign tmo_d = (TIMEOUT != 0) && (cnt_q == TLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            addr_q <= req_addr[1:0];
            f3_q   <= req_funct3;
            busy_q <= 1'b1;
            if (fault_d) begin
              state_q     <= S_ERR;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_we;
              bus_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 16'd1;
          if (bus_gnt && (we_q || bus_rvalid)) begin
            state_q     <= S_RESP;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : ext_d;
          end else if (tmo_d) begin
            state_q     <= S_RESP;
            bus_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (bus_gnt) begin
            state_q   <= S_WAIT;
            bus_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // a read landing on the last allowed cycle still completes
          if (bus_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ext_d;
          end else if (tmo_d) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        S_RESP, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
